satarx_crc: RTL and testbench
=============================

Name: satarx_crc

Overview:
- Receive-side CRC checker for the SATA link layer.
- Accepts a de-scrambled frame stream whose final dword (TLAST) is the CRC, and forwards only the payload dwords.
- Marks the final payload dword with TLAST, and reports CRC pass/fail on that beat.
- Sits between the link-layer receive framer and the transport-layer FIS parser.

Parameters:
- POLYNOMIAL, 32'h04c1_1db7, CRC generator polynomial.
- INITIAL_CRC, 32'h5232_5032, CRC seed at the start of each frame.
- OPT_LOWPOWER, 1'b1, zero M_AXIS_TDATA/TLAST/TUSER whenever M_AXIS_TVALID is low.

Ports:
- S_AXI_ACLK  input  1  clock.
- S_AXI_ARESETN  input  1  reset; asynchronous, active-low.
- S_AXIS_TVALID  input  1  incoming dword valid.
- S_AXIS_TREADY  output  1  incoming dword accepted.
- S_AXIS_TDATA  input  32  incoming dword (payload or CRC).
- S_AXIS_TLAST  input  1  marks the CRC dword, which ends the frame.
- M_AXIS_TVALID  output  1  payload dword valid.
- M_AXIS_TREADY  input  1  downstream ready.
- M_AXIS_TDATA  output  32  payload dword.
- M_AXIS_TLAST  output  1  last payload dword of the frame.
- M_AXIS_TUSER  output  1  CRC error; meaningful only when M_AXIS_TLAST is high.
- o_crc_err  output  1  one-cycle pulse on any CRC failure, including short frames.

Behaviour:
- Reset: all state is cleared asynchronously on S_AXI_ARESETN low; release is synchronous to S_AXI_ACLK.
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TUSER=0.
  - o_crc_err=0, crc=INITIAL_CRC, state=S_EMPTY, hold buffer=0.
- CRC update: MSB-first, one dword per cycle. For k=0..31: if (sreg[31]^dword[31-k]) then sreg={sreg[30:0],0}^POLYNOMIAL, else sreg={sreg[30:0],0}.
- The CRC register covers every accepted non-TLAST dword of the current frame.
- Why a hold buffer: a payload dword cannot be known to be last until the following (CRC) dword arrives, so one dword is held.
- Handshake: S_AXIS_TREADY = (state==S_EMPTY) || !M_AXIS_TVALID || M_AXIS_TREADY.
  - The output register is a standard skid-free AXI stage: it updates only when !M_AXIS_TVALID || M_AXIS_TREADY.
- States: S_EMPTY (no held dword) and S_HOLD (one payload dword held).
- Accept in S_EMPTY, TLAST=0:
  - hold<=TDATA; crc<=advance(crc,TDATA); go to S_HOLD.
  - No output beat.
- Accept in S_EMPTY, TLAST=1 (short frame: CRC with no payload):
  - Nothing is forwarded; o_crc_err pulses; crc<=INITIAL_CRC; stay in S_EMPTY.
- Accept in S_HOLD, TLAST=0:
  - Output beat {hold, TLAST=0, TUSER=0}.
  - hold<=TDATA; crc<=advance(crc,TDATA); stay in S_HOLD.
- Accept in S_HOLD, TLAST=1:
  - Output beat {hold, TLAST=1, TUSER=(TDATA!=crc)}.
  - o_crc_err pulses the same cycle if there is a mismatch.
  - crc<=INITIAL_CRC; go to S_EMPTY.
- Latency: a payload dword leaves one input beat after it arrived. The final payload dword appears one cycle after the CRC dword is accepted.
- Back-to-back frames: the first dword of a new frame may be accepted the cycle after the CRC dword; no idle cycle is needed.
- Backpressure: with M_AXIS_TVALID && !M_AXIS_TREADY in S_HOLD:
  - S_AXIS_TREADY=0;
  - hold and crc are frozen;
  - M_AXIS_* outputs are stable.
- Reset mid-frame: the held dword and any partial CRC are discarded; no TLAST beat is emitted.
- o_crc_err is registered, high for exactly one cycle per failing frame.

Optional Feature:
- Macro SATARX_CRC_STATS_EN.
- Defined:
  - Adds outputs o_good_frames[15:0] and o_bad_frames[15:0], each cleared on reset and saturating at 16'hffff.
  - o_good_frames increments on each frame-ending accept with a CRC match.
  - o_bad_frames increments on each mismatch or short frame.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame: bench model computes C = CRC over payload {32'h0000_0001, 32'h1234_5678, 32'hdead_beef}; send the 3 payload dwords then C with TLAST, M_AXIS_TREADY=1 → exactly 3 output beats, the third with TLAST=1 and TUSER=0; o_crc_err stays 0.
- Corrupt CRC: same frame with the CRC sent as C^32'h1 → third beat has TLAST=1, TUSER=1; o_crc_err pulses once, on the cycle the CRC dword is accepted.
- Short frame: single dword 32'h5232_5032 with TLAST → no output beat; o_crc_err pulses once; the next good frame passes.
- Backpressure: good frame with M_AXIS_TREADY toggling 1-0-0-1 randomly → output data/order unchanged; S_AXIS_TREADY low while the output is stalled in S_HOLD; TUSER=0.
- Back-to-back: two good frames with TVALID held high continuously → 2nd frame's first dword accepted the cycle after the 1st CRC; both TLAST beats have TUSER=0.
- Reset mid-frame: assert S_AXI_ARESETN low after 2 payload dwords → outputs clear asynchronously; no TLAST emitted; a subsequent good frame checks clean with INITIAL_CRC.

Source files
------------

// File: rtl/satarx_crc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : satarx_crc
// Purpose  : SATA link-layer receive CRC checker. Takes a de-scrambled frame
//            stream whose final dword (TLAST) is the CRC, forwards only the
//            payload dwords, marks the last payload dword with TLAST and
//            reports the CRC result on that beat through TUSER.
// Ports    : S_AXI_ACLK / S_AXI_ARESETN  clock, async active-low reset
//            S_AXIS_*                    frame stream in (payload + CRC)
//            M_AXIS_*                    payload stream out, TUSER = CRC error
//            o_crc_err                   one-cycle pulse per failing frame
//            o_good_frames/o_bad_frames  saturating frame counters, present
//                                        only with SATARX_CRC_STATS_EN
// Options  : `define SATARX_CRC_STATS_EN to add the frame statistics outputs.
// Revision : 1.0  initial release
// ============================================================================
module satarx_crc #(
    parameter logic [31:0] POLYNOMIAL   = 32'h04c1_1db7,
    parameter logic [31:0] INITIAL_CRC  = 32'h5232_5032,
    parameter bit          OPT_LOWPOWER = 1'b1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,
    output logic        o_crc_err
`ifdef SATARX_CRC_STATS_EN
    ,
    output logic [15:0] o_good_frames,
    output logic [15:0] o_bad_frames
`endif
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] hold_q;
    logic [31:0] crc_q;
    logic        m_valid_q;
    logic [31:0] m_data_q;
    logic        m_last_q;
    logic        m_user_q;
    logic        crc_err_q;

    logic        w_out_ready;
    logic        w_accept;
    logic        w_crc_match;
    logic [31:0] w_crc_next;

    // MSB-first serial CRC, unrolled over a full dword.
    function automatic logic [31:0] crc_advance(input logic [31:0] crc_in,
                                                input logic [31:0] dword);
        logic [31:0] sreg;
        sreg = crc_in;
        for (int k = 0; k < 32; k++) begin
            if (sreg[31] ^ dword[31-k])
                sreg = {sreg[30:0], 1'b0} ^ POLYNOMIAL;
            else
                sreg = {sreg[30:0], 1'b0};
        end
        return sreg;
    endfunction

    // The output register may load whenever it is empty or being drained.
    assign w_out_ready   = !m_valid_q || M_AXIS_TREADY;
    // In S_EMPTY no beat is produced, so input is never blocked there.
    assign S_AXIS_TREADY = (state_q == S_EMPTY) || w_out_ready;
    assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_crc_match   = (S_AXIS_TDATA == crc_q);
    assign w_crc_next    = crc_advance(crc_q, S_AXIS_TDATA);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_EMPTY;
            hold_q    <= 32'h0;
            crc_q     <= INITIAL_CRC;
            m_valid_q <= 1'b0;
            m_data_q  <= 32'h0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= 1'b0;

            // Drain the output stage; a new beat below overrides this.
            if (w_out_ready) begin
                m_valid_q <= 1'b0;
                if (OPT_LOWPOWER) begin
                    m_data_q <= 32'h0;
                    m_last_q <= 1'b0;
                    m_user_q <= 1'b0;
                end
            end

            if (w_accept) begin
                case (state_q)
                    S_EMPTY: begin
                        if (!S_AXIS_TLAST) begin
                            hold_q  <= S_AXIS_TDATA;
                            crc_q   <= w_crc_next;
                            state_q <= S_HOLD;
                        end else begin
                            // CRC dword with no payload: always an error.
                            crc_err_q <= 1'b1;
                            crc_q     <= INITIAL_CRC;
                        end
                    end
                    S_HOLD: begin
                        // Accept here implies the output stage is free.
                        m_valid_q <= 1'b1;
                        m_data_q  <= hold_q;
                        m_last_q  <= S_AXIS_TLAST;
                        m_user_q  <= S_AXIS_TLAST && !w_crc_match;
                        if (!S_AXIS_TLAST) begin
                            hold_q <= S_AXIS_TDATA;
                            crc_q  <= w_crc_next;
                        end else begin
                            crc_err_q <= !w_crc_match;
                            crc_q     <= INITIAL_CRC;
                            state_q   <= S_EMPTY;
                        end
                    end
                    default: state_q <= S_EMPTY;
                endcase
            end
        end
    end

    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TUSER  = m_user_q;
    assign o_crc_err     = crc_err_q;

`ifdef SATARX_CRC_STATS_EN
    logic [15:0] good_q;
    logic [15:0] bad_q;
    logic        w_frame_end;
    logic        w_frame_good;

    assign w_frame_end  = w_accept && S_AXIS_TLAST;
    assign w_frame_good = w_frame_end && (state_q == S_HOLD) && w_crc_match;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            good_q <= 16'h0;
            bad_q  <= 16'h0;
        end else if (w_frame_end) begin
            if (w_frame_good) begin
                if (good_q != 16'hffff)
                    good_q <= good_q + 16'd1;
            end else begin
                if (bad_q != 16'hffff)
                    bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign o_good_frames = good_q;
    assign o_bad_frames  = bad_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_satarx_crc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_satarx_crc
// Purpose  : Self-checking bench for satarx_crc. A reference model predicts
//            every output beat into a scoreboard queue at input accept time;
//            a monitor pops and compares on each output transfer.
// Revision : 1.0  initial release
// ============================================================================
module tb_satarx_crc;

    localparam logic [31:0] C_POLY = 32'h04c1_1db7;
    localparam logic [31:0] C_INIT = 32'h5232_5032;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'h0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_user;
    logic        crc_err;
`ifdef SATARX_CRC_STATS_EN
    logic [15:0] good_frames;
    logic [15:0] bad_frames;
`endif

    satarx_crc dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TLAST  (s_last),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TUSER  (m_user),
        .o_crc_err     (crc_err)
`ifdef SATARX_CRC_STATS_EN
        ,
        .o_good_frames (good_frames),
        .o_bad_frames  (bad_frames)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic [31:0] x;
        logic        fb;
        r = c;
        x = d;
        for (int k = 0; k < 32; k++) begin
            fb = r[31] ^ x[31];
            r  = r << 1;
            x  = x << 1;
            if (fb) r = r ^ C_POLY;
        end
        return r;
    endfunction

    // Reference model state and scoreboard ({data, last, user})
    logic [33:0] sb[$];
    logic        mh = 1'b0;
    logic [31:0] mhd = 32'h0;
    logic [31:0] mc = C_INIT;
    logic        exp_err = 1'b0;
    bit          bp_en = 1'b0;
    int          beats = 0;
    int          last_beats = 0;
    int          err_pulses = 0;
    time         t_first_acc = 0;
    time         t_last_acc = 0;

    task automatic model_accept(input logic [31:0] d, input logic l);
        if (!l) begin
            if (mh) sb.push_back({mhd, 1'b0, 1'b0});
            mhd = d;
            mh  = 1'b1;
            mc  = ref_crc(mc, d);
        end else begin
            if (mh) begin
                exp_err = (d != mc);
                sb.push_back({mhd, 1'b1, exp_err});
            end else begin
                exp_err = 1'b1;
            end
            mh = 1'b0;
            mc = C_INIT;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send_dword(input logic [31:0] d, input logic l);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!s_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_last_acc = $time;
        model_accept(d, l);
        #1;
        if (l) check("crc_err_pulse", {63'd0, crc_err}, {63'd0, exp_err});
    endtask

    task automatic send_frame(input logic [31:0] pl[$], input logic [31:0] xr, input bit keep_valid);
        logic [31:0] c;
        c = C_INIT;
        foreach (pl[i]) c = ref_crc(c, pl[i]);
        foreach (pl[i]) begin
            send_dword(pl[i], 1'b0);
            if (i == 0) t_first_acc = t_last_acc;
        end
        send_dword(c ^ xr, 1'b1);
        if (!keep_valid) s_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Random output backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor, sampled mid-cycle
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("s_ready", {63'd0, s_ready}, {63'd0, (!mh || !m_valid || m_ready)});
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        check("beat_unexpected", {30'd0, m_data, m_last, m_user}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_beat", {30'd0, m_data, m_last, m_user}, {30'd0, e});
                    end
                    beats++;
                    if (m_last) last_beats++;
                end
                if (!m_valid) check("idle_zero", {30'd0, m_data, m_last, m_user}, 64'd0);
                if (crc_err) err_pulses++;
            end
        end
    end

    initial begin
        logic [31:0] pl[$];
        int  b0, l0, e0;
        time t_end;

        pl = '{32'h0000_0001, 32'h1234_5678, 32'hdead_beef};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_data", {32'd0, m_data}, 64'd0);
        check("rst_last_user", {62'd0, m_last, m_user}, 64'd0);
        check("rst_err", {63'd0, crc_err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good frame
        b0 = beats; l0 = last_beats; e0 = err_pulses;
        send_frame(pl, 32'h0, 1'b0);
        settle();
        check("good_beats", 64'(beats - b0), 64'd3);
        check("good_last", 64'(last_beats - l0), 64'd1);
        check("good_err", 64'(err_pulses - e0), 64'd0);

        // Corrupt CRC
        b0 = beats; l0 = last_beats; e0 = err_pulses;
        send_frame(pl, 32'h1, 1'b0);
        settle();
        check("bad_beats", 64'(beats - b0), 64'd3);
        check("bad_err", 64'(err_pulses - e0), 64'd1);

        // Short frame, then a good frame
        b0 = beats; e0 = err_pulses;
        send_dword(32'h5232_5032, 1'b1);
        s_valid = 1'b0;
        settle();
        check("short_beats", 64'(beats - b0), 64'd0);
        check("short_err", 64'(err_pulses - e0), 64'd1);
        b0 = beats; e0 = err_pulses;
        send_frame(pl, 32'h0, 1'b0);
        settle();
        check("after_short_beats", 64'(beats - b0), 64'd3);
        check("after_short_err", 64'(err_pulses - e0), 64'd0);

        // Backpressure
        b0 = beats; e0 = err_pulses;
        bp_en = 1'b1;
        send_frame('{32'h0bad_f00d, 32'h5555_aaaa, 32'h0000_0000, 32'hffff_ffff, 32'h8000_0001},
                   32'h0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        bp_en   = 1'b0;
        m_ready = 1'b1;
        settle();
        check("bp_beats", 64'(beats - b0), 64'd5);
        check("bp_err", 64'(err_pulses - e0), 64'd0);

        // Back-to-back frames with TVALID held high
        b0 = beats; l0 = last_beats; e0 = err_pulses;
        send_frame(pl, 32'h0, 1'b1);
        t_end = t_last_acc;
        send_frame('{32'hcafe_babe, 32'h0102_0304}, 32'h0, 1'b0);
        check("b2b_gap", 64'(t_first_acc - t_end), 64'd10);
        settle();
        check("b2b_beats", 64'(beats - b0), 64'd5);
        check("b2b_last", 64'(last_beats - l0), 64'd2);
        check("b2b_err", 64'(err_pulses - e0), 64'd0);

        // Reset mid-frame
        l0 = last_beats;
        send_dword(32'h1111_2222, 1'b0);
        send_dword(32'h3333_4444, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {63'd0, m_valid}, 64'd0);
        check("midrst_data", {32'd0, m_data}, 64'd0);
        check("midrst_last_user", {62'd0, m_last, m_user}, 64'd0);
        mh = 1'b0;
        mc = C_INIT;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_no_last", 64'(last_beats - l0), 64'd0);
        b0 = beats; e0 = err_pulses;
        send_frame(pl, 32'h0, 1'b0);
        settle();
        check("postrst_beats", 64'(beats - b0), 64'd3);
        check("postrst_err", 64'(err_pulses - e0), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
